// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  localparam int BYTE_MASK_W = 4;

  typedef enum logic {
    IDLE,
    WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

endpackage

// File: rtl/bus_watchdog.sv
// rtl/bus_watchdog.sv - counts cycles spent waiting on the bus and flags a hung transaction
module bus_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The counter holds completed WAIT cycles, so the TIMEOUT-th cycle is the one at LIMIT.
  localparam logic [CW-1:0] LIMIT = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (TIMEOUT > 0) && en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one data-memory bus port between instruction fetch and load/store
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_req_valid,
  input  logic [31:0]            if_addr,
  output logic                   if_ready,
  output logic                   if_rvalid,
  output logic [31:0]            if_rdata,
  output logic                   if_err,
  input  logic                   d_req_valid,
  input  logic [31:0]            d_addr,
  input  logic [BYTE_MASK_W-1:0] d_we,
  input  logic [31:0]            d_wdata,
  output logic                   d_ready,
  output logic                   d_rvalid,
  output logic [31:0]            d_rdata,
  output logic                   d_err,
  output logic                   bus_req_valid,
  output logic [31:0]            bus_addr,
  output logic [BYTE_MASK_W-1:0] bus_we,
  output logic [31:0]            bus_wdata,
  input  logic                   bus_ack,
  input  logic [31:0]            bus_rdata
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  arb_state_t             state_q, state_d;
  owner_t                 owner_q, owner_d;
  logic [SW-1:0]          streak_q, streak_d;
  logic [31:0]            bus_addr_q, bus_addr_d;
  logic [BYTE_MASK_W-1:0] bus_we_q, bus_we_d;
  logic [31:0]            bus_wdata_q, bus_wdata_d;
  logic [31:0]            if_rdata_q, if_rdata_d;
  logic [31:0]            d_rdata_q, d_rdata_d;
  logic                   if_rvalid_q, if_rvalid_d;
  logic                   d_rvalid_q, d_rvalid_d;
  logic                   if_err_q, if_err_d;
  logic                   d_err_q, d_err_d;

  logic                   gnt_dside, gnt_ifside;
  logic                   expired;
  logic                   resp_err;
  logic [31:0]            resp_data;

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk_i    (clk),
    .rst_i    (rst),
    .clear_i  (gnt_dside | gnt_ifside),
    .en_i     (state_q == WAIT),
    .expired_o(expired)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    bus_addr_d  = bus_addr_q;
    bus_we_d    = bus_we_q;
    bus_wdata_d = bus_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_rvalid_d = 1'b0;
    d_rvalid_d  = 1'b0;
    if_err_d    = 1'b0;
    d_err_d     = 1'b0;
    gnt_dside   = 1'b0;
    gnt_ifside  = 1'b0;
    resp_err    = 1'b0;
    resp_data   = '0;

    case (state_q)
      IDLE: begin
        // D wins unless IF has already watched MAX_D_STREAK D grants go by.
        if (d_req_valid && !(if_req_valid && (streak_q == STREAK_MAX))) begin
          gnt_dside = 1'b1;
        end else if (if_req_valid) begin
          gnt_ifside = 1'b1;
        end

        if (gnt_dside) begin
          state_d     = WAIT;
          owner_d     = OWN_D;
          bus_addr_d  = d_addr;
          bus_we_d    = d_we;
          bus_wdata_d = d_wdata;
          if (if_req_valid) begin
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + SW'(1);
          end else begin
            streak_d = '0;
          end
        end else if (gnt_ifside) begin
          state_d     = WAIT;
          owner_d     = OWN_IF;
          bus_addr_d  = if_addr;
          bus_we_d    = '0;
          bus_wdata_d = '0;
          streak_d    = '0;
        end
      end

      WAIT: begin
        if (bus_ack || expired) begin
          // A real ack in the expiry cycle still counts as a normal completion.
          resp_err  = !bus_ack;
          resp_data = bus_ack ? bus_rdata : 32'h0;
          state_d   = IDLE;
          if (owner_q == OWN_D) begin
            d_rvalid_d = 1'b1;
            d_err_d    = resp_err;
            d_rdata_d  = resp_data;
          end else begin
            if_rvalid_d = 1'b1;
            if_err_d    = resp_err;
            if_rdata_d  = resp_data;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      streak_q    <= '0;
      bus_addr_q  <= '0;
      bus_we_q    <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_err_q    <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      bus_addr_q  <= bus_addr_d;
      bus_we_q    <= bus_we_d;
      bus_wdata_q <= bus_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_rvalid_q <= if_rvalid_d;
      d_rvalid_q  <= d_rvalid_d;
      if_err_q    <= if_err_d;
      d_err_q     <= d_err_d;
    end
  end

  // Readies are combinational, so keep them quiet while reset is held.
  assign if_ready      = gnt_ifside & ~rst;
  assign d_ready       = gnt_dside & ~rst;
  assign bus_req_valid = (state_q == WAIT);
  assign bus_addr      = bus_addr_q;
  assign bus_we        = bus_we_q;
  assign bus_wdata     = bus_wdata_q;
  assign if_rvalid     = if_rvalid_q;
  assign if_rdata      = if_rdata_q;
  assign if_err        = if_err_q;
  assign d_rvalid      = d_rvalid_q;
  assign d_rdata       = d_rdata_q;
  assign d_err         = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int TO   = 8;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid;
  logic [31:0] if_addr;
  logic        if_ready, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req_valid;
  logic [31:0] d_addr;
  logic [3:0]  d_we;
  logic [31:0] d_wdata;
  logic        d_ready, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        bus_req_valid;
  logic [31:0] bus_addr;
  logic [3:0]  bus_we;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MAX_D_STREAK(MAXS),
    .TIMEOUT     (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_valid (if_req_valid),
    .if_addr      (if_addr),
    .if_ready     (if_ready),
    .if_rvalid    (if_rvalid),
    .if_rdata     (if_rdata),
    .if_err       (if_err),
    .d_req_valid  (d_req_valid),
    .d_addr       (d_addr),
    .d_we         (d_we),
    .d_wdata      (d_wdata),
    .d_ready      (d_ready),
    .d_rvalid     (d_rvalid),
    .d_rdata      (d_rdata),
    .d_err        (d_err),
    .bus_req_valid(bus_req_valid),
    .bus_addr     (bus_addr),
    .bus_we       (bus_we),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
  } busreq_t;

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    int          delay;
    int          lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          ack_delay = 0;
  bit          stray_ack = 1'b0;
  resp_t       d_q[$];
  resp_t       if_q[$];
  busreq_t     b_q[$];
  bit          glog[$];
  logic [31:0] blog[$];
  logic [31:0] last_d = 32'h0;
  logic [31:0] last_if = 32'h0;
  bit          prev_brv = 1'b0;
  busreq_t     cur_bus;
  int          acc_d, acc_if, rc;
  logic [31:0] rd;
  logic        er, oth;
  vec_t        vec[7];
  bit          exp_pat[12];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] data_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {if_ready, if_rvalid, if_err, d_ready, d_rvalid, d_err, bus_req_valid, bus_we}, 96'h0);
    chk({tag, "_data"}, {if_rdata, d_rdata, bus_addr}, 96'h0);
    chk({tag, "_wdata"}, bus_wdata, 96'h0);
  endtask

  // Bus slave: acks after ack_delay WAIT cycles (negative means never).
  initial begin
    int wcnt;
    wcnt = 0;
    bus_ack = 1'b0;
    bus_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        bus_ack = 1'b0;
        wcnt = 0;
      end else if (bus_req_valid) begin
        bus_ack = (ack_delay >= 0) && (wcnt == ack_delay);
        bus_rdata = bus_ack ? data_fn(bus_addr) : $urandom;
        wcnt++;
      end else begin
        bus_ack = stray_ack;
        bus_rdata = $urandom;
        wcnt = 0;
      end
    end
  end

  // Scoreboard and bus monitor.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_brv = 1'b0;
      end else begin
        if (d_rvalid) begin
          if (d_q.size() == 0) begin
            chk("d_unexpected_rvalid", 1, 0);
            last_d = d_rdata;
          end else begin
            r = d_q.pop_front();
            chk("d_resp", {d_err, d_rdata}, {r.err, r.rdata});
            last_d = r.rdata;
          end
        end else begin
          chk("d_idle_hold", {d_err, d_rdata}, {1'b0, last_d});
        end
        if (if_rvalid) begin
          if (if_q.size() == 0) begin
            chk("if_unexpected_rvalid", 1, 0);
            last_if = if_rdata;
          end else begin
            r = if_q.pop_front();
            chk("if_resp", {if_err, if_rdata}, {r.err, r.rdata});
            last_if = r.rdata;
          end
        end else begin
          chk("if_idle_hold", {if_err, if_rdata}, {1'b0, last_if});
        end
        if (d_ready) glog.push_back(1'b1);
        if (if_ready) glog.push_back(1'b0);
        if (d_ready || if_ready) chk("single_ready", d_ready & if_ready, 0);
        if (bus_req_valid) begin
          if (!prev_brv) begin
            blog.push_back(bus_addr);
            if (b_q.size() == 0) begin
              chk("bus_unexpected_req", 1, 0);
              cur_bus = '{bus_addr, bus_we, bus_wdata};
            end else begin
              cur_bus = b_q.pop_front();
            end
          end
          chk("bus_payload", {bus_addr, bus_we, bus_wdata}, {cur_bus.addr, cur_bus.we, cur_bus.wdata});
        end
        prev_brv = bus_req_valid;
      end
    end
  end

  task automatic stream(input bit is_d, input logic [31:0] base, input logic [3:0] we,
                        input logic [31:0] wdata, input int n, output int acc);
    logic [31:0] a;
    bit got;
    bit e;
    acc = -1;
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      a = base + 32'(4 * i);
      if (is_d) begin
        d_req_valid = 1'b1;
        d_addr = a;
        d_we = we;
        d_wdata = wdata;
      end else begin
        if_req_valid = 1'b1;
        if_addr = a;
      end
      got = 1'b0;
      for (int k = 0; k < 60 && !got; k++) begin
        @(negedge clk);
        if (is_d ? d_ready : if_ready) got = 1'b1;
      end
      if (!got) begin
        chk(is_d ? "d_ready_timeout" : "if_ready_timeout", 0, 1);
        break;
      end
      acc = cyc;
      e = (ack_delay < 0) || (ack_delay >= TO);
      if (is_d) d_q.push_back('{e ? 32'h0 : data_fn(a), e});
      else if_q.push_back('{e ? 32'h0 : data_fn(a), e});
      b_q.push_back('{a, is_d ? we : 4'h0, is_d ? wdata : 32'h0});
      @(posedge clk);
      #1;
    end
    if (is_d) d_req_valid = 1'b0;
    else if_req_valid = 1'b0;
  endtask

  task automatic wait_resp(input bit is_d, output int rcyc, output logic [31:0] rdat,
                           output logic rerr, output logic other);
    bit got;
    got = 1'b0;
    rcyc = -1;
    rdat = 32'h0;
    rerr = 1'b0;
    other = 1'b0;
    for (int k = 0; k < 30 && !got; k++) begin
      @(negedge clk);
      if (is_d ? d_rvalid : if_rvalid) begin
        got = 1'b1;
        rcyc = cyc;
        rdat = is_d ? d_rdata : if_rdata;
        rerr = is_d ? d_err : if_err;
        other = is_d ? if_rvalid : d_rvalid;
      end
    end
    if (!got) chk("resp_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    vec[0] = '{1'b1, 32'h100, 4'h0, 32'h0,         2,  4, 32'hDEADBEEF,    1'b0};
    vec[1] = '{1'b1, 32'h104, 4'h3, 32'h0000ABCD,  0,  2, data_fn(32'h104), 1'b0};
    vec[2] = '{1'b0, 32'h80,  4'h0, 32'h0,        -1,  9, 32'h0,           1'b1};
    vec[3] = '{1'b1, 32'h300, 4'h0, 32'h0,         7,  9, data_fn(32'h300), 1'b0};
    vec[4] = '{1'b0, 32'h44,  4'h0, 32'h0,         8,  9, 32'h0,           1'b1};
    vec[5] = '{1'b0, 32'h48,  4'h0, 32'h0,         1,  3, data_fn(32'h48),  1'b0};
    vec[6] = '{1'b1, 32'h10C, 4'hF, 32'h12345678,  0,  2, data_fn(32'h10C), 1'b0};
    exp_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    rst = 1'b1;
    if_req_valid = 1'b0;
    if_addr = 32'h0;
    d_req_valid = 1'b0;
    d_addr = 32'h0;
    d_we = 4'h0;
    d_wdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      ack_delay = vec[i].delay;
      stream(vec[i].is_d, vec[i].addr, vec[i].we, vec[i].wdata, 1, acc_d);
      wait_resp(vec[i].is_d, rc, rd, er, oth);
      chk($sformatf("v%0d_latency", i), rc - acc_d, vec[i].lat);
      chk($sformatf("v%0d_rdata", i), rd, vec[i].exp_rdata);
      chk($sformatf("v%0d_err", i), er, vec[i].exp_err);
      chk($sformatf("v%0d_other_rvalid", i), oth, 0);
    end

    // Simultaneous requests: D first, IF granted in D's response cycle.
    repeat (2) @(posedge clk);
    ack_delay = 0;
    glog.delete();
    blog.delete();
    fork
      stream(1'b0, 32'h40, 4'h0, 32'h0, 1, acc_if);
      stream(1'b1, 32'h200, 4'h0, 32'h0, 1, acc_d);
    join
    repeat (4) @(posedge clk);
    chk("sim_if_accept_cycle", acc_if - acc_d, 2);
    chk("sim_grant_count", glog.size(), 2);
    if (glog.size() == 2) chk("sim_grant_order", {glog[0], glog[1]}, 2'b10);
    chk("sim_bus_count", blog.size(), 2);
    if (blog.size() == 2) chk("sim_bus_addr_order", {blog[0], blog[1]}, {32'h200, 32'h40});

    // Starvation guard with both sides held valid.
    glog.delete();
    fork
      stream(1'b1, 32'h1000, 4'h0, 32'h0, 10, acc_d);
      stream(1'b0, 32'h2000, 4'h0, 32'h0, 2, acc_if);
    join
    repeat (4) @(posedge clk);
    chk("starve_grant_count", glog.size(), 12);
    if (glog.size() == 12) begin
      for (int i = 0; i < 12; i++) chk($sformatf("starve_grant%0d", i), glog[i], exp_pat[i]);
    end

    // Watchdog expiry with a D request queued behind it.
    ack_delay = -1;
    fork
      begin
        stream(1'b0, 32'h80, 4'h0, 32'h0, 1, acc_if);
        for (int k = 1; k <= TO; k++) begin
          @(negedge clk);
          chk($sformatf("to_busreq_held%0d", k), bus_req_valid, 1);
        end
        @(negedge clk);
        chk("to_busreq_dropped", bus_req_valid, 0);
        chk("to_if_resp", {if_rvalid, if_err, if_rdata}, {1'b1, 1'b1, 32'h0});
      end
      begin
        repeat (3) @(posedge clk);
        stream(1'b1, 32'h900, 4'h0, 32'h0, 1, acc_d);
      end
    join
    chk("to_d_accept_cycle", acc_d - acc_if, 9);
    repeat (12) @(posedge clk);

    // bus_ack while IDLE must not produce a response.
    #1;
    stray_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("stray_no_rvalid", {d_rvalid, if_rvalid, bus_req_valid}, 3'b000);
    end
    stray_ack = 1'b0;
    repeat (2) @(posedge clk);

    // Asynchronous reset in the middle of a WAIT.
    ack_delay = -1;
    stream(1'b1, 32'h500, 4'hF, 32'hCAFE0001, 1, acc_d);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_zero("rst_async");
    d_q.delete();
    if_q.delete();
    b_q.delete();
    last_d = 32'h0;
    last_if = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ack_delay = 1;
    stream(1'b1, 32'h600, 4'h0, 32'h0, 1, acc_d);
    wait_resp(1'b1, rc, rd, er, oth);
    chk("post_rst_latency", rc - acc_d, 3);
    chk("post_rst_rdata", rd, data_fn(32'h600));
    chk("post_rst_err", er, 0);

    repeat (3) @(posedge clk);
    chk("queues_drained", d_q.size() + if_q.size() + b_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
